// File: rtl/weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : weight_fetch_ctrl
// Brief    : Read-side sequencer for a per-neuron weight BRAM. Reads words
//            0..DEPTH-1, absorbs the one-cycle BRAM read latency and streams
//            the words over valid/ready through a 2-entry skid FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module weight_fetch_ctrl #(
    parameter int DEPTH = 28,
    parameter int AW    = 5,
    parameter int DW    = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          START,
    output logic          BUSY,
    output logic          DONE,
    output logic [AW-1:0] ADDR,
    output logic          EN,
    output logic          WE,
    input  logic [DW-1:0] DO_IN,
    output logic [DW-1:0] W_DATA,
    output logic [AW-1:0] W_IDX,
    output logic          W_VALID,
    input  logic          W_READY,
    output logic          W_LAST
);

    localparam logic [1:0]    c_st_idle  = 2'd0;
    localparam logic [1:0]    c_st_run   = 2'd1;
    localparam logic [1:0]    c_st_drain = 2'd2;
    localparam logic [AW:0]   c_depth    = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_one      = (AW+1)'(1);
    localparam logic [AW-1:0] c_last_idx = AW'(DEPTH-1);

    logic [1:0]    r_state;
    logic [AW:0]   r_cnt;      // next address to issue; one bit wider so DEPTH fits
    logic [AW-1:0] r_addr;
    logic          r_en;       // also the "read in flight" flag for this cycle
    logic          r_busy;
    logic          r_done;
    logic [1:0]    r_count;    // FIFO occupancy, 0..2
    logic [DW-1:0] r_data0;    // entry 0 is always the head
    logic [DW-1:0] r_data1;
    logic [AW-1:0] r_idx0;
    logic [AW-1:0] r_idx1;

    logic          w_pop;
    logic          w_push;
    logic          w_start;
    logic          w_issue;
    logic          w_last_pop;
    logic [2:0]    w_occ;

    assign w_pop      = W_VALID & W_READY;
    assign w_push     = r_en;
    // Slots committed after this edge: buffered + in flight - leaving now.
    // A pop always implies r_count >= 1, so this cannot underflow.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_en} - {2'b00, w_pop};
    assign w_start    = (r_state == c_st_idle) & START;
    assign w_issue    = w_start |
                        ((r_state == c_st_run) && (r_cnt < c_depth) && (w_occ < 3'd2));
    assign w_last_pop = (r_state == c_st_drain) & w_pop & (r_idx0 == c_last_idx);

    // Sequencer: BRAM read issue, pass state and BUSY/DONE handshake
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= c_st_idle;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_en    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_issue) begin
                r_en   <= 1'b1;
                r_addr <= w_start ? '0 : r_cnt[AW-1:0];
                r_cnt  <= w_start ? c_one : (r_cnt + c_one);
            end else begin
                r_en   <= 1'b0;
            end
            case (r_state)
                c_st_idle: begin
                    if (START) begin
                        r_state <= c_st_run;
                        r_busy  <= 1'b1;
                    end
                end
                c_st_run: begin
                    if (r_cnt == c_depth) begin
                        r_state <= c_st_drain;
                    end
                end
                c_st_drain: begin
                    if (w_last_pop) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // Two-entry shifting FIFO: captures BRAM data one cycle after each issue
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_count <= 2'd0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_idx0  <= '0;
            r_idx1  <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) begin
                        r_data0 <= DO_IN;
                        r_idx0  <= r_addr;
                    end else begin
                        r_data1 <= DO_IN;
                        r_idx1  <= r_addr;
                    end
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_idx0  <= r_idx1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the head advances to the next word
                    if (r_count == 2'd1) begin
                        r_data0 <= DO_IN;
                        r_idx0  <= r_addr;
                    end else begin
                        r_data0 <= r_data1;
                        r_idx0  <= r_idx1;
                        r_data1 <= DO_IN;
                        r_idx1  <= r_addr;
                    end
                end
                default: ;
            endcase
        end
    end

    assign BUSY    = r_busy;
    assign DONE    = r_done;
    assign ADDR    = r_addr;
    assign EN      = r_en;
    assign WE      = 1'b0;
    assign W_DATA  = r_data0;
    assign W_IDX   = r_idx0;
    assign W_VALID = (r_count != 2'd0);
    assign W_LAST  = W_VALID & (r_idx0 == c_last_idx);

endmodule
`default_nettype wire

// File: tb/tb_weight_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_weight_fetch_ctrl
// Brief    : Scoreboard bench for weight_fetch_ctrl with a negedge BRAM model
//            and randomized consumer backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_fetch_ctrl;

    localparam int DEPTH = 28;
    localparam int AW    = 5;
    localparam int DW    = 16;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] idx;
    } beat_t;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          start   = 1'b0;
    logic          w_ready = 1'b0;
    logic          busy, done, en, we, w_valid, w_last;
    logic [AW-1:0] addr, w_idx;
    logic [DW-1:0] do_in = '0;
    logic [DW-1:0] w_data;

    logic [DW-1:0] mem [2**AW];
    beat_t         exp_q [$];

    int n_chk = 0, n_pass = 0;
    int cyc = 0;
    int ready_mode = 0;     // 0: always ready, 1: random 50%, 2: stalled
    bit model_busy = 0;
    bit exp_done = 0;
    int issue_idx = 0, issued = 0, popped = 0;
    int beats = 0, dones = 0;
    int acc_edge = 0, first_edge = -1, last_edge = -1;
    bit stall_prev = 0;
    logic [DW-1:0] stall_d;
    logic [AW-1:0] stall_i;

    weight_fetch_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .CLK(clk), .RST_N(rst_n), .START(start), .BUSY(busy), .DONE(done),
        .ADDR(addr), .EN(en), .WE(we), .DO_IN(do_in),
        .W_DATA(w_data), .W_IDX(w_idx), .W_VALID(w_valid),
        .W_READY(w_ready), .W_LAST(w_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // BRAM: samples ADDR/EN on the negedge, data seen by the DUT next posedge
    always @(negedge clk) if (en) do_in <= mem[addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Consumer ready driver
    initial forever begin
        @(posedge clk); #2;
        case (ready_mode)
            0:       w_ready = 1'b1;
            1:       w_ready = 1'($urandom % 2);
            default: w_ready = 1'b0;
        endcase
    end

    // Monitor: compares every presented beat against the scoreboard queue
    always @(negedge clk) begin
        if (rst_n) begin
            beat_t e;
            chk("we_low", 64'(we), 64'd0);
            chk("done_pulse", 64'(done), 64'(exp_done));
            exp_done = 0;
            if (done) begin
                dones++;
                chk("busy_low_in_done", 64'(busy), 64'd0);
            end
            if (en) begin
                chk("issue_addr", 64'(addr), 64'(issue_idx));
                issue_idx = (issue_idx + 1) % DEPTH;
                issued++;
            end
            chk("occupancy_le2", 64'(issued - popped <= 2), 64'd1);
            if (stall_prev) begin
                chk("stall_valid", 64'(w_valid), 64'd1);
                chk("stall_data", 64'(w_data), 64'(stall_d));
                chk("stall_idx", 64'(w_idx), 64'(stall_i));
            end
            if (w_valid) begin
                chk("busy_with_valid", 64'(busy), 64'd1);
                chk("last_flag", 64'(w_last), 64'(w_idx == AW'(DEPTH-1)));
            end else begin
                chk("last_without_valid", 64'(w_last), 64'd0);
            end
            if (w_valid && w_ready) begin
                popped++;
                beats++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(exp_q.size()), 64'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("beat_data", 64'(w_data), 64'(e.d));
                    chk("beat_idx", 64'(w_idx), 64'(e.idx));
                    if (e.idx == 0) first_edge = cyc + 1;
                    if (e.idx == AW'(DEPTH-1)) begin
                        last_edge  = cyc + 1;
                        model_busy = 0;
                        exp_done   = 1;
                    end
                end
            end
            stall_prev = w_valid && !w_ready;
            stall_d    = w_data;
            stall_i    = w_idx;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Asserts reset between edges and checks outputs clear asynchronously
    task automatic do_reset();
        @(posedge clk); #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_en", 64'(en), 64'd0);
        chk("rst_we", 64'(we), 64'd0);
        chk("rst_addr", 64'(addr), 64'd0);
        chk("rst_valid", 64'(w_valid), 64'd0);
        chk("rst_data", 64'(w_data), 64'd0);
        chk("rst_idx", 64'(w_idx), 64'd0);
        chk("rst_last", 64'(w_last), 64'd0);
        exp_q.delete();
        model_busy = 0; exp_done = 0; stall_prev = 0;
        issue_idx = 0; issued = 0; popped = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called at posedge+1; START is sampled at the next edge
    task automatic pulse_start();
        start = 1'b1;
        if (!model_busy) begin
            model_busy = 1;
            acc_edge   = cyc + 1;
            for (int i = 0; i < DEPTH; i++) exp_q.push_back('{d: mem[i], idx: AW'(i)});
        end
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((model_busy || exp_q.size() != 0) && n < budget) begin
            tick();
            n++;
        end
        chk("pass_within_budget", 64'(n < budget), 64'd1);
        tick();
        tick();
    endtask

    task automatic wait_head(input int idx, input int budget);
        int n = 0;
        while (!(w_valid && w_idx == AW'(idx)) && n < budget) begin
            tick();
            n++;
        end
        chk("head_reached", 64'(n < budget), 64'd1);
    endtask

    initial begin
        int b0, d0, n;
        for (int i = 0; i < 2**AW; i++) mem[i] = (i < DEPTH) ? 16'(16'h0100 + i) : 16'h0;
        do_reset();

        // Full-rate pass, START sampled at edge 10
        ready_mode = 0;
        while (cyc < 9) tick();
        b0 = beats; d0 = dones; first_edge = -1; last_edge = -1;
        pulse_start();
        wait_idle(200);
        chk("full_first_edge", 64'(first_edge), 64'(acc_edge + 2));
        chk("full_last_edge", 64'(last_edge), 64'(acc_edge + DEPTH + 1));
        chk("full_beats", 64'(beats - b0), 64'(DEPTH));
        chk("full_dones", 64'(dones - d0), 64'd1);

        // Backpressure with idx 5 at the head
        b0 = beats;
        pulse_start();
        wait_head(5, 100);
        ready_mode = 2;
        repeat (10) tick();
        chk("bp_en_dropped", 64'(en), 64'd0);
        chk("bp_valid_held", 64'(w_valid), 64'd1);
        chk("bp_data_held", 64'(w_data), 64'(mem[5]));
        chk("bp_idx_held", 64'(w_idx), 64'd5);
        ready_mode = 0;
        wait_idle(200);
        chk("bp_beats", 64'(beats - b0), 64'(DEPTH));

        // Random backpressure over three passes with fresh data
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < DEPTH; i++) mem[i] = 16'($urandom);
            b0 = beats; d0 = dones;
            ready_mode = 1;
            pulse_start();
            wait_idle(1000);
            chk("rand_beats", 64'(beats - b0), 64'(DEPTH));
            chk("rand_dones", 64'(dones - d0), 64'd1);
        end

        // START while busy is ignored; START in the DONE cycle is accepted
        for (int i = 0; i < DEPTH; i++) mem[i] = 16'(16'h0100 + i);
        ready_mode = 0;
        b0 = beats; d0 = dones;
        pulse_start();
        repeat (9) tick();
        pulse_start();
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(n < 200), 64'd1);
        pulse_start();
        wait_idle(200);
        chk("restart_beats", 64'(beats - b0), 64'(2 * DEPTH));
        chk("restart_dones", 64'(dones - d0), 64'd2);

        // Reset mid-pass at idx 12, then a clean pass from address 0
        ready_mode = 1;
        pulse_start();
        wait_head(12, 400);
        do_reset();
        b0 = beats; d0 = dones; first_edge = -1;
        pulse_start();
        wait_idle(1000);
        chk("post_rst_beats", 64'(beats - b0), 64'(DEPTH));
        chk("post_rst_dones", 64'(dones - d0), 64'd1);
        chk("post_rst_first_seen", 64'(first_edge >= 0), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/weight_fetch_ctrl.md
Name: weight_fetch_ctrl

Overview:
Read-side sequencer for the per-neuron weight BRAMs. On START it drives the BRAM ADDR/EN/WE port to read all DEPTH weights in order (address 0 to DEPTH-1). It absorbs the BRAM's one-cycle, negedge-clocked read latency and streams the words to the MAC datapath over a valid/ready interface with full backpressure. One instance sits between each weight BRAM and its neuron accumulator.

Parameters:
DEPTH, 28, number of weight words per BRAM
AW, 5, BRAM address width (2^AW >= DEPTH)
DW, 16, weight word width

Ports:
CLK  in  1  system clock, all logic posedge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle request to begin a fetch pass; sampled only in IDLE
BUSY  out  1  high from the edge accepting START until the last beat handshakes
DONE  out  1  one-cycle pulse after the last beat handshakes
ADDR  out  AW  BRAM address, registered
EN  out  1  BRAM enable, registered
WE  out  1  BRAM write enable, constant 0
DO_IN  in  DW  BRAM read data (BRAM DO)
W_DATA  out  DW  weight word at buffer head
W_IDX  out  AW  address of the W_DATA word
W_VALID  out  1  buffer head holds a valid word
W_READY  in  1  consumer accepts the word; a beat transfers when W_VALID and W_READY are both high
W_LAST  out  1  high with W_VALID when W_IDX == DEPTH-1

Behaviour:
- Reset (async, RST_N=0): state IDLE; ADDR=0, EN=0, WE=0, BUSY=0, DONE=0, W_VALID=0, W_DATA=0, W_IDX=0, W_LAST=0; buffer count=0; issue counter=0. Reset mid-pass drops all in-flight and buffered words. The next pass restarts at address 0.
- BRAM timing: ADDR/EN change only on posedge. The BRAM samples them on the following negedge. DO_IN is captured on the next posedge. Inflight = EN registered in the previous cycle, at most 1.
- Buffer: 2-entry FIFO of {data, idx}. The head drives W_DATA, W_IDX and W_LAST directly from registers.
- pop = W_VALID & W_READY.
- Issue condition: state RUN, issue counter < DEPTH, and (count + inflight - pop) < 2. When true, set EN<=1 and ADDR<=counter, then increment the counter. Otherwise set EN<=0 and hold ADDR.
- Capture: when inflight, push DO_IN with the issued idx. Push and pop in the same cycle leave count unchanged, with the head advancing correctly. The buffer never overflows.
- States:
  - IDLE: START=1 moves to RUN and sets BUSY<=1. The first issue (ADDR=0, EN=1) happens on the same edge.
  - RUN: keeps issuing per the issue condition. When the counter reaches DEPTH, moves to DRAIN.
  - DRAIN: EN=0. On the pop of the word with idx DEPTH-1, moves to IDLE, sets BUSY<=0 and DONE<=1 for one cycle.
- START outside IDLE is ignored. START in the DONE-pulse cycle is accepted, since the state is already IDLE.
- Latency: START is sampled at edge k; W_VALID=1 with idx 0 after edge k+1. With W_READY held high, beat i transfers at edge k+2+i, giving 1 word/cycle. The last beat transfers at edge k+DEPTH+1; DONE is high during the following cycle.
- W_DATA/W_IDX/W_LAST stay stable while W_VALID=1 and W_READY=0.
- WE is never asserted; this block does not write weights.

Test Plan:
- Reset: assert RST_N=0 mid-cycle -> all outputs 0 immediately (async), EN=0, no W_VALID.
- Full-rate pass: BRAM model mem[i]=16'h0100+i, W_READY=1, START at edge 10 -> EN high edges 10..37, ADDR 0..27; beats 0x0100..0x011B at edges 12..39; W_LAST only on idx 27; DONE pulse after edge 39; BUSY high edges 10..39.
- Backpressure: W_READY=0 for 10 cycles when idx 5 is at the head -> W_DATA stays 0x0105; EN drops once 2 words are buffered/inflight; no word lost or duplicated; idx sequence contiguous 0..27 after release.
- Random W_READY (50%, 3 seeds) -> exactly 28 beats, in order, data matches mem, DONE exactly once, buffer count never exceeds 2.
- START while BUSY (edge 20 of a pass) -> ignored; no restart, idx continuity kept. START in the DONE cycle -> new pass begins, idx 0 follows.
- Reset at idx 12 mid-pass, then START -> first beat idx 0, data 0x0100; full 28-beat pass completes; WE=0 throughout all tests.
